// File: rtl/vlm_speech_ctrl.sv
// vlm_speech_ctrl: CPU-side sequencer for the VLM5030 speech chip plus the speech ROM port.
//
// Purpose:
//   - Decodes CPU writes to the data latch (0x5000) and the control register (0x4000).
//   - Generates the VLM clock-enable tick (one CLK every CE_DIV CLKs).
//   - Stretches ST to at least ST_MIN ticks high followed by ST_GUARD ticks low; data-latch
//     writes arriving while ST is in progress are parked in a 1-deep register (last write wins)
//     and applied when the ST sequencer returns to idle.
//   - Shares the single-port speech ROM between the ROM downloader (absolute priority) and
//     VLM reads (request level, one-cycle ack pulse).
//
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   CPUAD/CPUWD/CPUWE   CPU address, write data, qualified write strobe
//   pause               global pause (honoured only when VLM_PAUSE_EN is defined)
//   vlm_ce              one-CLK VLM clock-enable tick
//   vlm_d/st/rst/vcu    data latch and control lines to the VLM core
//   vlm_busy            busy from the VLM core; busy_rd is the CPU-visible busy (0x6000 bit0)
//   vrom_req/a/ack/q    VLM ROM read handshake
//   DLCL/DLAD/DLDT/DLEN ROM downloader (DLCL is the same clock as CLK)
//
// Build option:
//   VLM_PAUSE_EN  when defined, pause=1 freezes the tick divider and suppresses vlm_ce (and with
//                 it every ST tick count). CPU writes and the ROM arbiter keep running.
module vlm_speech_ctrl #(
  parameter int unsigned CE_DIV   = 8,
  parameter int unsigned ST_MIN   = 4,
  parameter int unsigned ST_GUARD = 2,
  parameter int unsigned ROM_AW   = 14,
  parameter logic [17:0] DL_BASE  = 18'h1C000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       CPUAD,
  input  logic [7:0]        CPUWD,
  input  logic              CPUWE,
  input  logic              pause,
  output logic              vlm_ce,
  output logic [7:0]        vlm_d,
  output logic              vlm_st,
  output logic              vlm_rst,
  output logic              vlm_vcu,
  input  logic              vlm_busy,
  output logic              busy_rd,
  input  logic              vrom_req,
  input  logic [ROM_AW-1:0] vrom_a,
  output logic              vrom_ack,
  output logic [7:0]        vrom_q,
  input  logic              DLCL,
  input  logic [17:0]       DLAD,
  input  logic [7:0]        DLDT,
  input  logic              DLEN
);

  localparam logic [7:0]  DivLast   = 8'(CE_DIV - 1);
  localparam logic [7:0]  StMinLast = 8'(ST_MIN - 1);
  localparam logic [7:0]  GuardLast = 8'(ST_GUARD - 1);
  localparam int unsigned RomDepth  = 1 << ROM_AW;

  typedef enum logic [1:0] {StIdle, StHigh, StHold, StGuard} st_state_e;
  typedef enum logic [1:0] {AIdle, ARd, AAck} arb_state_e;

  // ---------------------------------------------------------------------------------------------
  // Pause qualification
  // ---------------------------------------------------------------------------------------------
  logic pause_eff;
  logic unused_sink;

`ifdef VLM_PAUSE_EN
  assign pause_eff   = pause;
  assign unused_sink = DLCL;
`else
  assign pause_eff   = 1'b0;
  assign unused_sink = DLCL ^ pause;
`endif

  // ---------------------------------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------------------------------
  logic [7:0] div_q;
  logic       div_last;

  assign div_last = (div_q == DivLast);
  assign vlm_ce   = div_last & ~pause_eff & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q <= '0;
    end else if (!pause_eff) begin
      div_q <= div_last ? 8'd0 : div_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // CPU registers and ST sequencer
  // ---------------------------------------------------------------------------------------------
  st_state_e  st_q, st_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       rst_q, rst_d;
  logic       vcu_q, vcu_d;
  logic       stq_q, stq_d;
  logic       retrig_q, retrig_d;
  logic       pend_q, pend_d;
  logic [7:0] pbyte_q, pbyte_d;
  logic [7:0] d_q, d_d;
  logic       ctrl_wr, data_wr, rise, exit_ok;

  assign ctrl_wr = CPUWE & (CPUAD == 16'h4000);
  assign data_wr = CPUWE & (CPUAD == 16'h5000);

  always_comb begin
    st_d     = st_q;
    tcnt_d   = tcnt_q;
    rst_d    = rst_q;
    vcu_d    = vcu_q;
    stq_d    = stq_q;
    retrig_d = retrig_q;
    pend_d   = pend_q;
    pbyte_d  = pbyte_q;
    d_d      = d_q;
    exit_ok  = 1'b0;

    if (ctrl_wr) begin
      rst_d = CPUWD[0];
      stq_d = CPUWD[1];
      vcu_d = CPUWD[2];
    end
    // Edge of the request level as it will be after this cycle's write.
    rise = stq_d & ~stq_q;

    if (!rst_q) begin
      case (st_q)
        StIdle: begin
          if (retrig_q || rise) begin
            st_d     = StHigh;
            tcnt_d   = '0;
            retrig_d = 1'b0;
          end
        end
        StHigh: begin
          if (vlm_ce) begin
            if (tcnt_q == StMinLast) begin
              st_d   = stq_d ? StHold : StGuard;
              tcnt_d = '0;
            end else begin
              tcnt_d = tcnt_q + 8'd1;
            end
          end
        end
        StHold: begin
          if (!stq_d) begin
            st_d   = StGuard;
            tcnt_d = '0;
          end
        end
        StGuard: begin
          if (rise) begin
            retrig_d = 1'b1;
          end
          if (vlm_ce) begin
            if (tcnt_q == GuardLast) begin
              st_d    = StIdle;
              exit_ok = 1'b1;
            end else begin
              tcnt_d = tcnt_q + 8'd1;
            end
          end
        end
        default: st_d = StIdle;
      endcase
    end

    // Data latch: direct when idle, otherwise parked until the sequencer drops back to idle.
    // A write landing on the exit cycle is newer than the parked byte, so it wins.
    if (st_q == StIdle) begin
      if (data_wr) begin
        d_d = CPUWD;
      end
    end else if (exit_ok) begin
      if (data_wr) begin
        d_d = CPUWD;
      end else if (pend_q) begin
        d_d = pbyte_q;
      end
      pend_d = 1'b0;
    end else if (data_wr) begin
      pend_d  = 1'b1;
      pbyte_d = CPUWD;
    end

    // Chip reset held: abort the pulse and drop any parked byte or remembered retrigger.
    if (rst_q) begin
      st_d     = StIdle;
      tcnt_d   = '0;
      retrig_d = 1'b0;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q     <= StIdle;
      tcnt_q   <= '0;
      rst_q    <= 1'b1;
      vcu_q    <= 1'b0;
      stq_q    <= 1'b0;
      retrig_q <= 1'b0;
      pend_q   <= 1'b0;
      pbyte_q  <= '0;
      d_q      <= '0;
    end else begin
      st_q     <= st_d;
      tcnt_q   <= tcnt_d;
      rst_q    <= rst_d;
      vcu_q    <= vcu_d;
      stq_q    <= stq_d;
      retrig_q <= retrig_d;
      pend_q   <= pend_d;
      pbyte_q  <= pbyte_d;
      d_q      <= d_d;
    end
  end

  assign vlm_d   = d_q;
  assign vlm_rst = rst_q;
  assign vlm_vcu = vcu_q;
  assign vlm_st  = (st_q == StHigh) | (st_q == StHold);
  assign busy_rd = vlm_busy | (st_q != StIdle) | pend_q;

  // ---------------------------------------------------------------------------------------------
  // Speech ROM arbiter
  // ---------------------------------------------------------------------------------------------
  logic [7:0]        mem [RomDepth];
  arb_state_e        arb_q, arb_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [7:0]        q_q;
  logic              dl_hit, rd_en;

  assign dl_hit = DLEN & (DLAD[17:ROM_AW] == DL_BASE[17:ROM_AW]);

  always_ff @(posedge CLK) begin
    if (dl_hit) begin
      mem[DLAD[ROM_AW-1:0]] <= DLDT;
    end
  end

  always_comb begin
    arb_d  = arb_q;
    addr_d = addr_q;
    rd_en  = 1'b0;
    case (arb_q)
      AIdle: begin
        if (!dl_hit && vrom_req) begin
          arb_d  = ARd;
          addr_d = vrom_a;
        end
      end
      ARd: begin
        // A download write owns the port this cycle; the read simply retries.
        if (!dl_hit) begin
          rd_en = 1'b1;
          arb_d = AAck;
        end
      end
      AAck:    arb_d = AIdle;
      default: arb_d = AIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      arb_q  <= AIdle;
      addr_q <= '0;
      q_q    <= '0;
    end else begin
      arb_q  <= arb_d;
      addr_q <= addr_d;
      if (rd_en) begin
        q_q <= mem[addr_q];
      end
    end
  end

  assign vrom_ack = (arb_q == AAck);
  assign vrom_q   = q_q;

endmodule

// File: tb/tb_vlm_speech_ctrl.sv
// Self-checking bench for vlm_speech_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural reference model kept in this file.
module tb_vlm_speech_ctrl;

  localparam int          CE_DIV   = 8;
  localparam int          ST_MIN   = 4;
  localparam int          ST_GUARD = 2;
  localparam logic [17:0] DL_BASE  = 18'h1C000;

  localparam int P_IDLE  = 0;
  localparam int P_HIGH  = 1;
  localparam int P_HOLD  = 2;
  localparam int P_GUARD = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] CPUAD;
  logic [7:0]  CPUWD;
  logic        CPUWE;
  logic        pause;
  logic        vlm_busy;
  logic        vrom_req;
  logic [13:0] vrom_a;
  logic [17:0] DLAD;
  logic [7:0]  DLDT;
  logic        DLEN;
  wire         DLCL;
  wire         vlm_ce, vlm_st, vlm_rst, vlm_vcu, busy_rd, vrom_ack;
  wire  [7:0]  vlm_d, vrom_q;

  assign DLCL = CLK;

  always #5 CLK = ~CLK;

  vlm_speech_ctrl dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CPUAD    (CPUAD),
    .CPUWD    (CPUWD),
    .CPUWE    (CPUWE),
    .pause    (pause),
    .vlm_ce   (vlm_ce),
    .vlm_d    (vlm_d),
    .vlm_st   (vlm_st),
    .vlm_rst  (vlm_rst),
    .vlm_vcu  (vlm_vcu),
    .vlm_busy (vlm_busy),
    .busy_rd  (busy_rd),
    .vrom_req (vrom_req),
    .vrom_a   (vrom_a),
    .vrom_ack (vrom_ack),
    .vrom_q   (vrom_q),
    .DLCL     (DLCL),
    .DLAD     (DLAD),
    .DLDT     (DLDT),
    .DLEN     (DLEN)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          m_run;      // unpaused cycles since reset release
  logic [7:0]  m_d;
  logic        m_rst, m_vcu, m_stq;
  int          m_phase;
  int          m_rem;      // ticks still to go in HIGH / GUARD
  logic        m_flag;
  logic        m_pend;
  logic [7:0]  m_pb;
  int          m_arb;      // 0 idle, 1 read pending, 2 ack
  logic [13:0] m_addr;
  logic [7:0]  m_q;
  logic [7:0]  m_mem [16384];

  function automatic logic is_paused();
`ifdef VLM_PAUSE_EN
    return pause;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic ce_now();
    return !RESET && !is_paused() && ((m_run % CE_DIV) == CE_DIV - 1);
  endfunction

  task automatic model_step();
    logic cw, dw, hit, ce, stq_n, rise, exiting;
    int   old;
    cw  = CPUWE && (CPUAD == 16'h4000);
    dw  = CPUWE && (CPUAD == 16'h5000);
    hit = DLEN && ((DLAD >> 14) == (DL_BASE >> 14));
    ce  = ce_now();
    if (hit) m_mem[DLAD[13:0]] = DLDT;
    if (RESET) begin
      m_run = 0; m_d = 8'h00; m_rst = 1'b1; m_vcu = 1'b0; m_stq = 1'b0;
      m_phase = P_IDLE; m_rem = 0; m_flag = 1'b0; m_pend = 1'b0; m_pb = 8'h00;
      m_arb = 0; m_addr = 14'h0; m_q = 8'h00;
      return;
    end
    if (!is_paused()) m_run++;
    stq_n   = cw ? CPUWD[1] : m_stq;
    rise    = stq_n && !m_stq;
    exiting = 1'b0;
    old     = m_phase;
    if (m_rst) begin
      if (old == P_IDLE && dw) m_d = CPUWD;
      m_phase = P_IDLE; m_flag = 1'b0; m_pend = 1'b0;
    end else begin
      case (old)
        P_IDLE: if (m_flag || rise) begin
          m_phase = P_HIGH; m_rem = ST_MIN; m_flag = 1'b0;
        end
        P_HIGH: if (ce) begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = stq_n ? P_HOLD : P_GUARD;
            m_rem = ST_GUARD;
          end
        end
        P_HOLD: if (!stq_n) begin
          m_phase = P_GUARD; m_rem = ST_GUARD;
        end
        default: begin
          if (rise) m_flag = 1'b1;
          if (ce) begin
            m_rem--;
            if (m_rem == 0) begin
              m_phase = P_IDLE; exiting = 1'b1;
            end
          end
        end
      endcase
      if (old == P_IDLE) begin
        if (dw) m_d = CPUWD;
      end else if (exiting) begin
        if (dw) m_d = CPUWD;
        else if (m_pend) m_d = m_pb;
        m_pend = 1'b0;
      end else if (dw) begin
        m_pend = 1'b1; m_pb = CPUWD;
      end
    end
    if (cw) begin
      m_rst = CPUWD[0]; m_vcu = CPUWD[2];
    end
    m_stq = stq_n;
    case (m_arb)
      0: if (!hit && vrom_req) begin m_arb = 1; m_addr = vrom_a; end
      1: if (!hit) begin m_q = m_mem[m_addr]; m_arb = 2; end
      default: m_arb = 0;
    endcase
  endtask

  task automatic check_outputs();
    chk("vlm_ce", 32'(vlm_ce), 32'(ce_now()));
    chk("vlm_d", 32'(vlm_d), 32'(m_d));
    chk("vlm_st", 32'(vlm_st), 32'(m_phase == P_HIGH || m_phase == P_HOLD));
    chk("vlm_rst", 32'(vlm_rst), 32'(m_rst));
    chk("vlm_vcu", 32'(vlm_vcu), 32'(m_vcu));
    chk("busy_rd", 32'(busy_rd), 32'(vlm_busy || m_phase != P_IDLE || m_pend));
    chk("vrom_ack", 32'(vrom_ack), 32'(m_arb == 2));
    chk("vrom_q", 32'(vrom_q), 32'(m_q));
  endtask

  // Observation accumulators for the directed scenarios
  int   acc_tick_hi, acc_st_hi, acc_rise, acc_busy_gap, acc_seen22, acc_ce;
  logic prev_st = 1'b0;
  logic last_ce, last_ack;
  logic [7:0] last_q;

  task automatic clr_acc();
    acc_tick_hi = 0; acc_st_hi = 0; acc_rise = 0; acc_busy_gap = 0; acc_seen22 = 0; acc_ce = 0;
  endtask

  // Inputs are set by the caller just after a posedge; outputs are sampled on the negedge.
  task automatic cycle();
    @(negedge CLK);
    if (chk_en) check_outputs();
    last_ce  = vlm_ce;
    last_ack = vrom_ack;
    last_q   = vrom_q;
    if (vlm_ce) acc_ce++;
    if (vlm_ce && vlm_st) acc_tick_hi++;
    if (vlm_st) acc_st_hi++;
    if (vlm_st && !prev_st) acc_rise++;
    prev_st = vlm_st;
    if (m_phase != P_IDLE && !busy_rd) acc_busy_gap++;
    if (vlm_d == 8'h22) acc_seen22++;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    CPUAD = a; CPUWD = d; CPUWE = 1'b1;
    cycle();
    CPUWE = 1'b0;
  endtask

  task automatic rand_inputs();
    int sel;
    RESET = ($urandom_range(0, 499) == 0);
    CPUWE = ($urandom_range(0, 99) < 8);
    sel = $urandom_range(0, 3);
    CPUAD = (sel == 0) ? 16'h4000 : (sel == 1) ? 16'h5000 : (sel == 2) ? 16'h6000 :
            16'($urandom);
    CPUWD = 8'($urandom);
    if (CPUAD == 16'h4000) CPUWD[0] = ($urandom_range(0, 19) == 0);
    vlm_busy = ($urandom_range(0, 7) == 0);
    pause    = ($urandom_range(0, 15) == 0);
    DLEN = ($urandom_range(0, 3) == 0);
    DLAD = ($urandom_range(0, 1) == 1 ? DL_BASE : 18'h0C000) | 18'($urandom_range(0, 63));
    DLDT = 8'($urandom);
    if (!vrom_req) begin
      if ($urandom_range(0, 3) == 0) begin
        vrom_req = 1'b1;
        vrom_a   = 14'($urandom_range(0, 63));
      end
    end else if (last_ack && $urandom_range(0, 1) == 1) begin
      vrom_req = 1'b0;
    end
  endtask

  initial begin
    int first, lat;
    logic [7:0] q_at_ack;
    RESET = 1'b1; CPUAD = 16'h0; CPUWD = 8'h0; CPUWE = 1'b0; pause = 1'b0; vlm_busy = 1'b0;
    vrom_req = 1'b0; vrom_a = 14'h0; DLAD = 18'h0; DLDT = 8'h0; DLEN = 1'b0;
    clr_acc();

    // Reset held 3 CLK, then locate the first tick
    cycle();
    chk_en = 1'b1;
    idle(2);
    RESET = 1'b0;
    chk("rst_after_reset", 32'(vlm_rst), 32'd1);
    first = -1;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (last_ce && first < 0) first = n;
    end
    chk("first_ce", 32'(first), 32'(CE_DIV - 1));

    // Preload the ROM window used by reads
    DLEN = 1'b1;
    for (int i = 0; i < 64; i++) begin
      DLAD = DL_BASE | 18'(i);
      DLDT = 8'($urandom);
      cycle();
    end
    DLEN = 1'b0;

    // Short ST
    wr(16'h4000, 8'h00);
    idle(2);
    clr_acc();
    wr(16'h4000, 8'h02);
    wr(16'h4000, 8'h00);
    idle(80);
    chk("short_rise", 32'(acc_rise), 32'd1);
    chk("short_ticks", 32'(acc_tick_hi), 32'(ST_MIN));
    chk("short_busy_gap", 32'(acc_busy_gap), 32'd0);

    // Deferred latch
    clr_acc();
    wr(16'h5000, 8'h11);
    wr(16'h4000, 8'h02);
    wr(16'h4000, 8'h00);
    wr(16'h5000, 8'h22);
    wr(16'h5000, 8'h33);
    chk("defer_hold", 32'(vlm_d), 32'h11);
    idle(80);
    chk("defer_final", 32'(vlm_d), 32'h33);
    chk("defer_no22", 32'(acc_seen22), 32'd0);

    // Held ST, then a retrigger written during GUARD
    clr_acc();
    wr(16'h4000, 8'h02);
    idle(99);
    wr(16'h4000, 8'h00);
    chk("held_width", 32'(acc_st_hi), 32'd100);
    clr_acc();
    wr(16'h4000, 8'h02);
    idle(60);
    wr(16'h4000, 8'h00);
    idle(30);
    chk("retrig_rise", 32'(acc_rise), 32'd1);

    // ROM arbitration: two download hits while the read is pending
    DLAD = DL_BASE | 18'h010; DLDT = 8'hA5; DLEN = 1'b1;
    cycle();
    DLEN = 1'b0;
    vrom_req = 1'b1; vrom_a = 14'h010;
    DLAD = DL_BASE | 18'h020; DLDT = 8'h5A;
    lat = -1; q_at_ack = 8'h00;
    for (int k = 0; k < 16; k++) begin
      DLEN = (k == 1 || k == 2);
      cycle();
      if (last_ack && lat < 0) begin
        lat = k; q_at_ack = last_q;
        vrom_req = 1'b0;
      end
    end
    DLEN = 1'b0;
    chk("rom_latency", 32'(lat), 32'd4);
    chk("rom_q", 32'(q_at_ack), 32'hA5);

`ifdef VLM_PAUSE_EN
    // Pause mid-HIGH
    idle(5);
    clr_acc();
    wr(16'h4000, 8'h02);
    wr(16'h4000, 8'h00);
    idle(10);
    first = acc_ce;
    pause = 1'b1;
    idle(50);
    chk("pause_ce", 32'(acc_ce - first), 32'd0);
    chk("pause_st", 32'(vlm_st), 32'd1);
    pause = 1'b0;
    idle(60);
    chk("pause_width", 32'(acc_tick_hi), 32'(ST_MIN));
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
